// File: rtl/batalha_pkg.sv
// Shared types and constants for the battleship turn controller and its helpers.
package batalha_pkg;

  localparam int POS_W          = 3;
  localparam int DEB_CYCLES_DEF = 1000000;

  typedef enum logic [1:0] {
    HIDE,
    SHOOT,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/debounce_key.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a one-cycle
// press pulse on the debounced falling edge of an active-low key.
module debounce_key
  import batalha_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             key_sync;
  logic             level_q;
  logic             armed_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: the synchronizer flops carry no reset; they only hold sampled copies of key_n.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[0], key_n};
  end

  assign key_sync = sync_q[1];

  // armed_q blocks the press from a button that was already held when reset released.
  // NOTE: sequential state uses <= so every register reads pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b1;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_sync) armed_q <= 1'b1;
      if (key_sync != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= key_sync;
          cnt_q   <= '0;
          press   <= ~key_sync & armed_q;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/jogada_turnos.sv
// Battleship move-entry/turn controller: hide ship, then up to MAX_SHOTS guesses.
// Define JOGADA_REPEAT_FILTER_EN to reject repeated guesses (adds repeat_rej).
module jogada_turnos
  import batalha_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int MAX_SHOTS  = 6
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             key_n,
  input  logic [POS_W-1:0] sw_p1,
  input  logic [POS_W-1:0] sw_p2,
  input  logic             hit,
  output logic [POS_W-1:0] ship_pos,
  output logic [POS_W-1:0] guess_pos,
  output logic             guess_valid,
  output logic             turn_p2,
  output logic [2:0]       shots,
  output logic             game_over,
  output logic             p2_wins
`ifdef JOGADA_REPEAT_FILTER_EN
  ,
  output logic             repeat_rej
`endif
);

  state_t state_q, state_d;
  logic   press;
  logic   take_ship, take_guess, finish, win;

  debounce_key #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key (
    .clk  (CLOCK_50),
    .reset(reset),
    .key_n(key_n),
    .press(press)
  );

`ifdef JOGADA_REPEAT_FILTER_EN
  logic [7:0] tried_q;
  logic       rej;
`endif

  // While guess_valid is high the comparator is still working, so SHOOT holds one
  // extra cycle and WAIT lands exactly on the cycle hit becomes valid.
  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    state_d    = state_q;
    take_ship  = 1'b0;
    take_guess = 1'b0;
    finish     = 1'b0;
    win        = 1'b0;
    turn_p2    = 1'b0;
`ifdef JOGADA_REPEAT_FILTER_EN
    rej        = 1'b0;
`endif
    case (state_q)
      HIDE: begin
        if (press) begin
          take_ship = 1'b1;
          state_d   = SHOOT;
        end
      end
      SHOOT: begin
        turn_p2 = ~guess_valid;
        if (guess_valid) begin
          state_d = WAIT;
        end else if (press) begin
`ifdef JOGADA_REPEAT_FILTER_EN
          if (tried_q[sw_p2]) rej = 1'b1;
          else                take_guess = 1'b1;
`else
          take_guess = 1'b1;
`endif
        end
      end
      WAIT: begin
        if (hit) begin
          finish  = 1'b1;
          win     = 1'b1;
          state_d = DONE;
        end else if (shots == 3'(MAX_SHOTS)) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SHOOT;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = HIDE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= HIDE;
      ship_pos    <= '0;
      guess_pos   <= '0;
      guess_valid <= 1'b0;
      shots       <= '0;
      game_over   <= 1'b0;
      p2_wins     <= 1'b0;
    end else begin
      state_q     <= state_d;
      guess_valid <= take_guess;
      if (take_ship) ship_pos <= sw_p1;
      if (take_guess) begin
        guess_pos <= sw_p2;
        shots     <= shots + 1'b1;
      end
      if (finish) begin
        game_over <= 1'b1;
        p2_wins   <= win;
      end
    end
  end

`ifdef JOGADA_REPEAT_FILTER_EN
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tried_q    <= '0;
      repeat_rej <= 1'b0;
    end else begin
      repeat_rej <= rej;
      if (take_guess) tried_q[sw_p2] <= 1'b1;
    end
  end
`endif

endmodule
